hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum consecutive data-memory freeze cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 id_opcode  input  7  opcode of the instruction in ID.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices in ID.
REQ-006 ex_memread  input  1  load in EX.
REQ-007 ex_rd  input  5  destination register of the EX instruction.
REQ-008 ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-009 mem_req  input  1  data-memory access in MEM (memread|memwrite).
REQ-010 dmem_ack  input  1  data memory completes the MEM access this cycle.
REQ-011 stall  output  1  load-use bubble; drives the control decoder stall input.
REQ-012 pc_write, ifid_write  output  1 each  PC / IF-ID register update enables.
REQ-013 ifid_flush, idex_flush  output  1 each  squash IF/ID, ID/EX contents.
REQ-014 hold  output  1  freeze all pipeline registers (ID/EX, EX/MEM, MEM/WB).
REQ-015 mem_timeout  output  1  sticky data-memory timeout error.
REQ-016 stall_cnt, flush_cnt  output  16 each  load-use bubble cycles / taken-branch flush events.

Function
REQ-017 rs1 used: id_opcode in {0000011, 0100011, 0110011, 1100011, 0010011, 1100111}; rs2 used: id_opcode in {0100011, 0110011, 1100011}.
REQ-018 Load-use hazard (lu) = ex_memread & ex_rd!=0 & ((rs1 used & ex_rd==id_rs1) | (rs2 used & ex_rd==id_rs2)).
REQ-019 FSM states RUN and MEM_WAIT; wait_cnt is an 8-bit count of consecutive hold cycles.
REQ-020 Freeze condition (frz): (state RUN & mem_req & !dmem_ack & !mem_timeout) | (state MEM_WAIT & !dmem_ack).
REQ-021 frz: hold=1, pc_write=0, ifid_write=0, stall=0, both flushes 0; lu and ex_branch_taken ignored and not counted.
REQ-022 RUN to MEM_WAIT when frz, wait_cnt<=1; RUN with mem_req & dmem_ack same cycle does not freeze.
REQ-023 MEM_WAIT with dmem_ack=1: hold=0 that cycle, pipeline advances, next state RUN, wait_cnt<=0.
REQ-024 MEM_WAIT, dmem_ack=0, wait_cnt<TIMEOUT-1: wait_cnt increments.
REQ-025 MEM_WAIT, dmem_ack=0, wait_cnt==TIMEOUT-1: hold=1 that cycle, next state RUN, mem_timeout<=1; hold never exceeds TIMEOUT consecutive cycles.
REQ-026 mem_timeout is sticky until reset; while set, mem_req never causes a freeze.
REQ-027 No frz and ex_branch_taken: ifid_flush=1, idex_flush=1, stall=0, pc_write=1, ifid_write=1; flush_cnt increments; lu suppressed and not counted.
REQ-028 No frz, no taken branch, lu: stall=1, pc_write=0, ifid_write=0, flushes 0, hold=0; stall_cnt increments.
REQ-029 Otherwise: stall=0, pc_write=1, ifid_write=1, flushes 0, hold=0.
REQ-030 Priority: freeze > branch flush > load-use stall.
REQ-031 stall_cnt and flush_cnt saturate at 0xFFFF.
REQ-032 All outputs are combinational from state and inputs except counters and mem_timeout (registered); zero added latency.

Reset
REQ-033 rst_n=0 at a clock edge: state RUN, wait_cnt 0, mem_timeout 0, stall_cnt 0, flush_cnt 0, regardless of current state, including mid-MEM_WAIT.
REQ-034 While rst_n=0: stall=1, pc_write=0, ifid_write=0, hold=0, ifid_flush=0, idex_flush=0.

Verification
REQ-035 ex_memread=1, ex_rd=5, id_opcode=0110011, id_rs1=5 for one cycle -> stall=1, pc_write=0, ifid_write=0 that cycle; stall_cnt 0->1.
REQ-036 Same stimulus with ex_rd=0, or id_opcode=0010011 with only id_rs2=5 matching -> stall=0; stall_cnt unchanged.
REQ-037 Load-use and ex_branch_taken=1 same cycle -> ifid_flush=idex_flush=1, stall=0; flush_cnt +1, stall_cnt unchanged.
REQ-038 mem_req=1, dmem_ack first high on cycle 3 -> hold=1 cycles 0-2, hold=0 cycle 3, state RUN cycle 4; concurrent lu/branch ignored.
REQ-039 TIMEOUT=4, mem_req=1, dmem_ack=0 forever -> hold=1 cycles 0-3, mem_timeout=1 and hold=0 from cycle 4 onward.
REQ-040 rst_n=0 for one edge during MEM_WAIT; counters preset to 0xFFFF, then one further lu -> stall_cnt stays 0xFFFF before reset; all state cleared after reset.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and a
// bounded data-memory freeze with a sticky timeout flag and event counters.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        hold,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;
    localparam logic [7:0] LP_LAST  = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_timeout;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_lu;
    logic w_frz;

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (id_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: w_rs1_used = 1'b1;
            7'b0100011, 7'b0110011, 7'b1100011: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                  ((w_rs1_used && (ex_rd == id_rs1)) ||
                   (w_rs2_used && (ex_rd == id_rs2)));

    assign w_frz = ((r_state == RUN) && mem_req && !dmem_ack && !r_mem_timeout) ||
                   ((r_state == MEM_WAIT) && !dmem_ack);

    // Priority: reset bubble > memory freeze > branch flush > load-use stall
    always_comb begin
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        hold       = 1'b0;
        if (!rst_n) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (w_frz) begin
            hold       = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_lu) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_frz) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                default: begin
                    if (dmem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == LP_LAST) begin
                        r_state       <= RUN;
                        r_wait_cnt    <= '0;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_frz) begin
            if (ex_branch_taken) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 16'd1;
            end else if (w_lu) begin
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4; each task checks one feature.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_branch_taken, mem_req, dmem_ack;
    logic        stall, pc_write, ifid_write, ifid_flush, idex_flush, hold, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // {stall, pc_write, ifid_write, ifid_flush, idex_flush, hold}
    logic [5:0] w_o;
    assign w_o = {stall, pc_write, ifid_write, ifid_flush, idex_flush, hold};

    localparam logic [5:0] O_RUN   = 6'b011000;
    localparam logic [5:0] O_STALL = 6'b100000;
    localparam logic [5:0] O_FLUSH = 6'b011110;
    localparam logic [5:0] O_HOLD  = 6'b000001;

    hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ack(dmem_ack),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .hold(hold),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst_n = 1'b1; id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_memread = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic set_lu;
        ex_memread = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd5; id_rs2 = 5'd0;
    endtask

    task automatic test_reset;
        idle; rst_n = 1'b0; set_lu; #1;
        n_vec++; if (w_o !== O_STALL) begin n_err++; $display("FAIL reset_outs: got %b expected %b", w_o, O_STALL); end
        cyc;
        n_vec++; if ({mem_timeout, stall_cnt, flush_cnt} !== 33'd0) begin n_err++;
            $display("FAIL reset_state: got to=%b sc=%h fc=%h expected 0", mem_timeout, stall_cnt, flush_cnt); end
        idle;
    endtask

    task automatic test_load_use;
        set_lu; #1;
        n_vec++; if (w_o !== O_STALL) begin n_err++; $display("FAIL lu_rs1_outs: got %b expected %b", w_o, O_STALL); end
        cyc;
        n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_rs1_cnt: got %0d expected 1", stall_cnt); end
        id_opcode = 7'b0100011; id_rs1 = 5'd0; id_rs2 = 5'd5; #1;
        n_vec++; if (w_o !== O_STALL) begin n_err++; $display("FAIL lu_rs2_outs: got %b expected %b", w_o, O_STALL); end
        cyc;
        n_vec++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL lu_rs2_cnt: got %0d expected 2", stall_cnt); end
        idle;
    endtask

    task automatic test_no_hazard;
        set_lu; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL nh_rd0: got %b expected %b", w_o, O_RUN); end
        cyc;
        set_lu; id_opcode = 7'b0010011; id_rs1 = 5'd3; id_rs2 = 5'd5; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL nh_itype_rs2: got %b expected %b", w_o, O_RUN); end
        cyc;
        set_lu; ex_memread = 1'b0; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL nh_noload: got %b expected %b", w_o, O_RUN); end
        cyc;
        set_lu; id_opcode = 7'b0110111; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL nh_lui: got %b expected %b", w_o, O_RUN); end
        cyc;
        n_vec++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL nh_cnt: got %0d expected 2", stall_cnt); end
        idle;
    endtask

    task automatic test_branch;
        set_lu; ex_branch_taken = 1'b1; #1;
        n_vec++; if (w_o !== O_FLUSH) begin n_err++; $display("FAIL br_outs: got %b expected %b", w_o, O_FLUSH); end
        cyc;
        n_vec++; if ({stall_cnt, flush_cnt} !== {16'd2, 16'd1}) begin n_err++;
            $display("FAIL br_cnt: got sc=%0d fc=%0d expected sc=2 fc=1", stall_cnt, flush_cnt); end
        idle;
    endtask

    task automatic test_mem_wait;
        for (int c = 0; c < 3; c++) begin
            set_lu; ex_branch_taken = 1'b1; mem_req = 1'b1; dmem_ack = 1'b0; #1;
            n_vec++; if (w_o !== O_HOLD) begin n_err++; $display("FAIL mw_hold c%0d: got %b expected %b", c, w_o, O_HOLD); end
            cyc;
        end
        idle; mem_req = 1'b1; dmem_ack = 1'b1; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL mw_ack: got %b expected %b", w_o, O_RUN); end
        cyc;
        idle; #1;
        n_vec++; if (w_o !== O_RUN) begin n_err++; $display("FAIL mw_run: got %b expected %b", w_o, O_RUN); end
        n_vec++; if ({stall_cnt, flush_cnt} !== {16'd2, 16'd1}) begin n_err++;
            $display("FAIL mw_cnt: got sc=%0d fc=%0d expected sc=2 fc=1", stall_cnt, flush_cnt); end
        cyc;
    endtask

    task automatic test_timeout;
        idle; mem_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++; if ({mem_timeout, w_o} !== {1'b0, O_HOLD}) begin n_err++;
                $display("FAIL to_hold c%0d: got to=%b o=%b expected to=0 o=%b", c, mem_timeout, w_o, O_HOLD); end
            cyc;
        end
        #1;
        n_vec++; if ({mem_timeout, w_o} !== {1'b1, O_RUN}) begin n_err++;
            $display("FAIL to_c4: got to=%b o=%b expected to=1 o=%b", mem_timeout, w_o, O_RUN); end
        cyc;
        ex_branch_taken = 1'b1; #1;
        n_vec++; if ({mem_timeout, w_o} !== {1'b1, O_FLUSH}) begin n_err++;
            $display("FAIL to_c5: got to=%b o=%b expected to=1 o=%b", mem_timeout, w_o, O_FLUSH); end
        cyc;
        n_vec++; if (flush_cnt !== 16'd2) begin n_err++; $display("FAIL to_fcnt: got %0d expected 2", flush_cnt); end
        idle;
    endtask

    task automatic test_sat_reset;
        idle; rst_n = 1'b0; cyc; idle;
        force dut.r_stall_cnt = 16'hFFFF;
        force dut.r_flush_cnt = 16'hFFFF;
        #1;
        release dut.r_stall_cnt;
        release dut.r_flush_cnt;
        set_lu; #1;
        n_vec++; if (w_o !== O_STALL) begin n_err++; $display("FAIL sat_lu_outs: got %b expected %b", w_o, O_STALL); end
        cyc;
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_stall: got %h expected ffff", stall_cnt); end
        idle; ex_branch_taken = 1'b1; cyc;
        n_vec++; if (flush_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_flush: got %h expected ffff", flush_cnt); end
        idle; mem_req = 1'b1; cyc; cyc;
        rst_n = 1'b0; set_lu; #1;
        n_vec++; if (w_o !== O_STALL) begin n_err++; $display("FAIL rstw_outs: got %b expected %b", w_o, O_STALL); end
        cyc;
        idle; mem_req = 1'b1;
        n_vec++; if ({mem_timeout, stall_cnt, flush_cnt} !== 33'd0) begin n_err++;
            $display("FAIL rstw_state: got to=%b sc=%h fc=%h expected 0", mem_timeout, stall_cnt, flush_cnt); end
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++; if (w_o !== O_HOLD) begin n_err++; $display("FAIL rstw_hold c%0d: got %b expected %b", c, w_o, O_HOLD); end
            cyc;
        end
        #1;
        n_vec++; if ({mem_timeout, w_o} !== {1'b1, O_RUN}) begin n_err++;
            $display("FAIL rstw_to: got to=%b o=%b expected to=1 o=%b", mem_timeout, w_o, O_RUN); end
        idle;
    endtask

    initial begin
        idle; rst_n = 1'b0;
        cyc;
        test_reset;
        test_load_use;
        test_no_hazard;
        test_branch;
        test_mem_wait;
        test_timeout;
        test_sat_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
